// File: rtl/xgriscv_fetch_buffer.sv
// Instruction fetch front-end: credit-limited request issue, response FIFO and redirect flush.
// Optional FETCH_BUF_BYPASS_EN lets a response reach decode in the cycle it arrives when the FIFO is empty.
module xgriscv_fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [31:0]   lastPc;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] fifoCount;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;

  logic          fifoEmpty;
  logic          grant;
  logic          rvConsume;
  logic          rvAccept;
  logic          bypass;
  logic          pushEn;
  logic          popEn;
  logic [CW+1:0] creditSum;
  logic [31:0]   redirectTarget;
  logic [1:0]    unusedPcBits;

  // Every queued entry, outstanding request and pending discard holds one credit.
  assign creditSum   = (CW+2)'(fifoCount) + (CW+2)'(inflight) + (CW+2)'(discard);
  assign imem_req_o  = !reset && !redirect_i && (creditSum < DEPTH_W);
  assign imem_addr_o = fetchPc;
  assign grant       = imem_req_o && imem_gnt_i;
  assign fifoEmpty   = (fifoCount == '0);

  // rvConsume: response retires a discard or an inflight slot; rvAccept: it also carries live data.
  assign rvConsume = imem_rvalid_i && ((discard != '0) || (inflight != '0));
  assign rvAccept  = imem_rvalid_i && (discard == '0) && (inflight != '0) && !redirect_i;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = rvAccept && fifoEmpty && !stall_i;
`else
  assign bypass = 1'b0;
`endif

  assign pushEn         = rvAccept && !bypass;
  assign popEn          = !fifoEmpty && !stall_i;
  assign redirectTarget = {redirect_pc_i[31:2], 2'b00};
  assign unusedPcBits   = redirect_pc_i[1:0];

  always_comb begin
    instr_valid_o = !fifoEmpty || bypass;
    instr_o       = NOP_INSTR;
    pc_o          = lastPc;
    if (!fifoEmpty) begin
      instr_o = instrMem[rdPtr];
      pc_o    = pcMem[rdPtr];
    end else if (bypass) begin
      instr_o = imem_rdata_i;
      pc_o    = respPc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc   <= RESET_PC;
      respPc    <= RESET_PC;
      lastPc    <= RESET_PC;
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= '0;
      inflight  <= '0;
      discard   <= '0;
    end else begin
      if (redirect_i) begin
        // Requests still in the memory pipe turn into discards; a response arriving now retires one of them.
        fetchPc   <= redirectTarget;
        respPc    <= redirectTarget;
        inflight  <= '0;
        discard   <= discard + inflight - CW'(rvConsume);
        fifoCount <= '0;
        rdPtr     <= '0;
        wrPtr     <= '0;
      end else begin
        if (grant) fetchPc <= fetchPc + 32'd4;
        if (rvAccept) respPc <= respPc + 32'd4;
        inflight <= inflight + CW'(grant) - CW'(rvAccept);
        if (imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
        fifoCount <= fifoCount + CW'(pushEn) - CW'(popEn);
        if (pushEn) wrPtr <= wrPtr + AW'(1);
        if (popEn) rdPtr <= rdPtr + AW'(1);
      end
      if (popEn) begin
        lastPc <= pcMem[rdPtr];
      end else if (bypass) begin
        lastPc <= respPc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn && !reset) begin
      instrMem[wrPtr] <= imem_rdata_i;
      pcMem[wrPtr]    <= respPc;
    end
  end

endmodule
